// File: rtl/reflet_ram_pkg.sv
// Shared definitions for the reflet single-clock RAM: sweep FSM encoding
// and the read-latency helper.
package reflet_ram_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } sweep_state_t;

   function automatic int read_latency(input int outReg);
      return 1 + outReg;
   endfunction

endpackage

// File: rtl/reflet_ram_clear.sv
// Clear-sweep FSM: walks cnt from 0 to done_addr, one address per cycle,
// with busy registered alongside the state.
module reflet_ram_clear
   import reflet_ram_pkg::*;
#(
   parameter int addrSize     = 7,
   parameter int clearOnReset = 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                clear,
   input  logic [addrSize-1:0] done_addr,
   output logic [addrSize-1:0] cnt,
   output logic                busy
);

   sweep_state_t r_state;

   // A clear request always wins, so a request mid-sweep restarts at 0.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= (clearOnReset != 0) ? CLEAR : IDLE;
         cnt     <= '0;
         busy    <= (clearOnReset != 0);
      end else if (clear) begin
         r_state <= CLEAR;
         cnt     <= '0;
         busy    <= 1'b1;
      end else if (r_state == CLEAR) begin
         if (cnt == done_addr) begin
            r_state <= IDLE;
            cnt     <= '0;
            busy    <= 1'b0;
         end else begin
            cnt     <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/reflet_ram_sc.sv
// Single-clock RAM with one write and one read port, optional output
// register, selectable read-during-write behaviour and a clear sweep.
module reflet_ram_sc
   import reflet_ram_pkg::*;
#(
   parameter int addrSize     = 7,
   parameter int size         = 128,
   parameter int depth        = 8,
   parameter int outReg       = 0,
   parameter int bypass       = 1,
   parameter int clearOnReset = 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                enable,
   input  logic                clear,
   input  logic                read_en,
   input  logic [addrSize-1:0] addr_read,
   input  logic                write_en,
   input  logic [addrSize-1:0] addr_write,
   input  logic [depth-1:0]    data_in,
   output logic [depth-1:0]    data_out,
   output logic                read_valid,
   output logic                busy,
   output logic                range_err
);

   localparam int                LAT  = read_latency(outReg);
   localparam logic [addrSize:0] LIM  = (addrSize+1)'(size);
   localparam logic [addrSize-1:0] LAST = addrSize'(size - 1);

   logic [depth-1:0]    r_mem [size];
   logic [addrSize-1:0] w_cnt;
   logic                w_busy;
   logic                w_rd_acc, w_wr_acc, w_rd_oor, w_wr_oor;
   logic                w_we;
   logic [addrSize-1:0] w_wa;
   logic [depth-1:0]    w_wd;
   logic [depth-1:0]    r_rd_p1;
   logic                r_vld_p1;
   logic                r_rerr;

   reflet_ram_clear #(
      .addrSize     (addrSize),
      .clearOnReset (clearOnReset)
   ) u_clear (
      .clk       (clk),
      .reset     (reset),
      .clear     (clear),
      .done_addr (LAST),
      .cnt       (w_cnt),
      .busy      (w_busy)
   );

   assign busy     = w_busy;
   assign w_rd_acc = read_en  & enable & ~w_busy;
   assign w_wr_acc = write_en & enable & ~w_busy;
   assign w_rd_oor = ({1'b0, addr_read}  >= LIM);
   assign w_wr_oor = ({1'b0, addr_write} >= LIM);

   // The sweep owns the single write port while busy.
   assign w_we = w_busy | (w_wr_acc & ~w_wr_oor);
   assign w_wa = w_busy ? w_cnt : addr_write;
   assign w_wd = w_busy ? '0 : data_in;

   always_ff @(posedge clk) begin
      if (w_we) r_mem[w_wa] <= w_wd;
   end

   // Stage p1: array read; a same-address write forwards data_in in write-first mode.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_vld_p1 <= 1'b0;
         r_rd_p1  <= '0;
         r_rerr   <= 1'b0;
      end else begin
         r_vld_p1 <= w_rd_acc;
         r_rerr   <= (w_rd_acc & w_rd_oor) | (w_wr_acc & w_wr_oor);
         if (w_rd_acc) begin
            if (w_rd_oor)
               r_rd_p1 <= '0;
            else if ((bypass != 0) && w_wr_acc && !w_wr_oor && (addr_write == addr_read))
               r_rd_p1 <= data_in;
            else
               r_rd_p1 <= r_mem[addr_read];
         end
      end
   end

   assign range_err = r_rerr;

   // Stage p2: optional output register, holds between valid pulses.
   if (LAT > 1) begin : g_oreg
      logic [depth-1:0] r_rd_p2;
      logic             r_vld_p2;
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            r_vld_p2 <= 1'b0;
            r_rd_p2  <= '0;
         end else begin
            r_vld_p2 <= r_vld_p1;
            if (r_vld_p1) r_rd_p2 <= r_rd_p1;
         end
      end
      assign data_out   = r_rd_p2;
      assign read_valid = r_vld_p2;
   end else begin : g_noreg
      assign data_out   = r_rd_p1;
      assign read_valid = r_vld_p1;
   end

endmodule

// File: tb/tb_reflet_ram_sc.sv
// Directed bench: a default instance (latency 1, write-first, 128 words) and
// a second instance (size 100, latency 2, read-first) share the stimulus.
module tb_reflet_ram_sc;

   logic       clk, rst, en, clr, re, we;
   logic [6:0] ra, wa;
   logic [7:0] wd;
   logic [7:0] d0_out, d1_out;
   logic       d0_vld, d0_busy, d0_rerr;
   logic       d1_vld, d1_busy, d1_rerr;

   int n_chk = 0;
   int n_err = 0;

   reflet_ram_sc dut0 (
      .clk(clk), .reset(rst), .enable(en), .clear(clr),
      .read_en(re), .addr_read(ra), .write_en(we), .addr_write(wa), .data_in(wd),
      .data_out(d0_out), .read_valid(d0_vld), .busy(d0_busy), .range_err(d0_rerr)
   );

   reflet_ram_sc #(
      .addrSize(7), .size(100), .depth(8), .outReg(1), .bypass(0), .clearOnReset(1)
   ) dut1 (
      .clk(clk), .reset(rst), .enable(en), .clear(clr),
      .read_en(re), .addr_read(ra), .write_en(we), .addr_write(wa), .data_in(wd),
      .data_out(d1_out), .read_valid(d1_vld), .busy(d1_busy), .range_err(d1_rerr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs;
      clr = 1'b0; re = 1'b0; we = 1'b0; ra = '0; wa = '0; wd = '0;
   endtask

   task automatic count_busy(input string tag);
      int c0 = 0, c1 = 0;
      for (int i = 0; i < 200; i++) begin
         if (d0_busy) c0++;
         if (d1_busy) c1++;
         tick();
      end
      check_eq({tag, "_busy0"}, c0, 128);
      check_eq({tag, "_busy1"}, c1, 100);
   endtask

   initial begin
      int flag;
      en = 1'b1; rst = 1'b1;
      idle_inputs();
      repeat (3) tick();
      check_eq("rst_out0",  d0_out,  0);
      check_eq("rst_vld0",  d0_vld,  0);
      check_eq("rst_rerr0", d0_rerr, 0);
      check_eq("rst_busy0", d0_busy, 1);
      check_eq("rst_out1",  d1_out,  0);
      check_eq("rst_busy1", d1_busy, 1);
      rst = 1'b0;
      count_busy("init");

      // read of address 5 after the sweep
      re = 1; ra = 5; tick(); re = 0;
      check_eq("rd5_vld0", d0_vld, 1);
      check_eq("rd5_out0", d0_out, 8'h00);
      check_eq("rd5_vld1_early", d1_vld, 0);
      tick();
      check_eq("rd5_vld0_pulse", d0_vld, 0);
      check_eq("rd5_vld1", d1_vld, 1);
      check_eq("rd5_out1", d1_out, 8'h00);

      // write then read next cycle
      we = 1; wa = 3; wd = 8'hA5; tick(); we = 0;
      re = 1; ra = 3; tick(); re = 0;
      check_eq("wr3_out0", d0_out, 8'hA5);
      check_eq("wr3_vld1_early", d1_vld, 0);
      tick();
      check_eq("wr3_vld1", d1_vld, 1);
      check_eq("wr3_out1", d1_out, 8'hA5);
      check_eq("wr3_hold0", d0_out, 8'hA5);

      // same-edge read and write to address 10
      we = 1; wa = 10; wd = 8'h11; tick();
      wd = 8'h3C; re = 1; ra = 10; tick(); we = 0; re = 0;
      check_eq("rdw_byp0", d0_out, 8'h3C);
      tick();
      check_eq("rdw_old1", d1_out, 8'h11);
      re = 1; ra = 10; tick(); re = 0;
      check_eq("rdw_later0", d0_out, 8'h3C);
      tick();
      check_eq("rdw_later1", d1_out, 8'h3C);

      // enable low blocks both ports
      en = 0; we = 1; wa = 3; wd = 8'hEE; re = 1; ra = 3; tick();
      check_eq("en_vld0", d0_vld, 0);
      en = 1; we = 0; tick(); re = 0;
      check_eq("en_keep0", d0_out, 8'hA5);
      tick();
      check_eq("en_keep1", d1_out, 8'hA5);

      // out-of-range access on the 100-word instance
      re = 1; ra = 120; tick(); re = 0;
      check_eq("oor_rd_vld0", d0_vld, 1);
      check_eq("oor_rd_rerr0", d0_rerr, 0);
      check_eq("oor_rd_rerr1", d1_rerr, 1);
      tick();
      check_eq("oor_rd_vld1", d1_vld, 1);
      check_eq("oor_rd_out1", d1_out, 8'h00);
      check_eq("oor_rd_rerr1_pulse", d1_rerr, 0);
      we = 1; wa = 110; wd = 8'hC3; tick(); we = 0;
      check_eq("oor_wr_rerr1", d1_rerr, 1);
      check_eq("oor_wr_rerr0", d0_rerr, 0);
      re = 1; ra = 110; tick();
      check_eq("alias_110_0", d0_out, 8'hC3);
      check_eq("alias_rerr1", d1_rerr, 1);
      ra = 46; tick();
      check_eq("alias_46_0", d0_out, 8'h00);
      check_eq("alias_110_1", d1_out, 8'h00);
      ra = 10; tick(); re = 0;
      check_eq("alias_10_0", d0_out, 8'h3C);
      check_eq("alias_46_1", d1_out, 8'h00);
      tick();
      check_eq("alias_10_1", d1_out, 8'h3C);

      // fill, then clear with traffic during busy
      for (int a = 0; a < 128; a++) begin
         we = 1; wa = 7'(a); wd = 8'(a + 1); tick();
      end
      we = 0;
      re = 1; ra = 99; tick(); re = 0;
      check_eq("fill_99_0", d0_out, 8'h64);
      tick();
      check_eq("fill_99_1", d1_out, 8'h64);
      clr = 1; tick(); clr = 0;
      flag = 0;
      begin
         int c0 = 0, c1 = 0;
         for (int i = 0; i < 200; i++) begin
            if (d0_busy) c0++;
            if (d1_busy) c1++;
            if (d0_vld || d1_vld || d0_rerr || d1_rerr) flag = 1;
            if (i < 90) begin
               re = 1; ra = 7'(i); we = 1; wa = 7'(i); wd = 8'hFF;
            end else begin
               re = 0; we = 0;
            end
            tick();
         end
         check_eq("clr_busy0", c0, 128);
         check_eq("clr_busy1", c1, 100);
      end
      check_eq("clr_no_traffic", flag, 0);

      for (int a = 0; a < 129; a++) begin
         re = (a < 128); ra = 7'(a); tick();
         if (a < 128) check_eq($sformatf("swept0_%0d", a), {d0_vld, d0_out}, 9'h100);
         if (a > 0)   check_eq($sformatf("swept1_%0d", a - 1), {d1_vld, d1_out}, 9'h100);
      end
      re = 0;

      // reset in the middle of a sweep
      we = 1; wa = 7; wd = 8'h77; tick(); we = 0;
      re = 1; ra = 7; tick(); re = 0; tick();
      check_eq("pre_rst_out0", d0_out, 8'h77);
      check_eq("pre_rst_out1", d1_out, 8'h77);
      clr = 1; tick(); clr = 0;
      repeat (40) tick();
      #2 rst = 1;
      #1;
      check_eq("async_out0",  d0_out,  0);
      check_eq("async_out1",  d1_out,  0);
      check_eq("async_vld1",  d1_vld,  0);
      check_eq("async_busy0", d0_busy, 1);
      tick();
      rst = 0;
      count_busy("restart");

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
